// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one signed 9x9 multiplier among NREQ requesters.
// One operation in flight: IDLE grants, MUL registers the product, RESP holds it until accepted.
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [9*NREQ-1:0] req_a,
    input  logic [9*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [16:0]       rsp_result,
    output logic              rsp_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    cand;
    logic [IDW-1:0]    grant_id;
    logic              grant_any;
    logic [NREQ-1:0]   grant_oh;
    logic              handshake;
    logic signed [8:0] sel_a, sel_b;
    logic signed [8:0] op_a, op_b;
    logic [IDW-1:0]    op_id;
    logic signed [17:0] prod;

    // Search starts one past the last granted requester.
    always_comb begin
        grant_oh  = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(ptr) + i) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        if (grant_any) grant_oh[grant_id] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_id == IDW'(k)) begin
                sel_a = req_a[9*k +: 9];
                sel_b = req_b[9*k +: 9];
            end
        end
    end

    // rst_n gates the grant so req_ready is zero for the whole reset window.
    assign req_ready = (state == IDLE && rst_n) ? grant_oh : '0;
    assign handshake = (state == IDLE) && grant_any;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign prod      = op_a * op_b;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = grant_any ? MUL : IDLE;
            MUL:     state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= IDW'(NREQ - 1);
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
        end else begin
            if (handshake) begin
                ptr   <= grant_id;
                op_a  <= sel_a;
                op_b  <= sel_b;
                op_id <= grant_id;
            end
            // Only 65536 = (-256)*(-256) leaves the 17-bit signed range.
            if (state == MUL) begin
                rsp_id     <= op_id;
                rsp_result <= prod[16:0];
                rsp_ovf    <= prod[17] ^ prod[16];
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level round-robin/multiply model.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [9*NREQ-1:0] req_a, req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [16:0]       rsp_result;
    logic              rsp_ovf;
    logic              busy;

    logic signed [8:0] op_a [NREQ];
    logic signed [8:0] op_b [NREQ];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_a[9*k +: 9] = op_a[k];
            req_b[9*k +: 9] = op_b[k];
        end
    end

    mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ovf(rsp_ovf),
        .busy(busy)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task clear_ops;
        for (int k = 0; k < NREQ; k++) begin
            op_a[k] = '0;
            op_b[k] = '0;
        end
    endtask

    task apply_reset;
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task test_reset;
        clear_ops();
        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        #3;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_result !== 17'd0) begin errors++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result); end
        checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL reset_rsp_ovf: got %b want 0", rsp_ovf); end
        apply_reset();
    endtask

    task test_single;
        apply_reset();
        op_a[0] = 9'sd5;
        op_b[0] = -9'sd3;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_mul_ready: got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_mul_rv: got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_mul_busy: got %b want 1", busy); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rv: got %b want 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_result !== 17'h1FFF1) begin errors++; $display("FAIL single_result: got %h want 1fff1", rsp_result); end
        checks++; if (rsp_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b want 0", rsp_ovf); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got rv=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task test_round_robin;
        int n;
        apply_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        n = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (req_ready !== 4'b0000) begin
                checks++;
                if (req_ready !== 4'(1 << (n % NREQ)) || cyc != 3 * n) begin
                    errors++;
                    $display("FAIL rr_grant: got %b at cycle %0d want %b at cycle %0d", req_ready, cyc, 4'(1 << (n % NREQ)), 3 * n);
                end
                n++;
            end
            tick();
        end
        checks++; if (n != 5) begin errors++; $display("FAIL rr_count: got %0d grants want 5", n); end
        req_valid = '0;
        tick();
        tick();
    endtask

    task test_backpressure;
        int waited;
        apply_reset();
        op_a[2] = -9'sd100;
        op_b[2] = 9'sd7;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        checks++; if (waited != 2) begin errors++; $display("FAIL bp_latency: got %0d cycles want 2", waited); end
        req_valid = '1;
        op_a[2] = 9'sd1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 17'(-700) || rsp_ovf !== 1'b0 ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got rv=%b id=%0d res=%h ovf=%b rdy=%b busy=%b want 1 2 %h 0 0000 1",
                         rsp_valid, rsp_id, rsp_result, rsp_ovf, req_ready, busy, 17'(-700));
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got rv=%b busy=%b want 0 0", rsp_valid, busy); end
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
        req_valid = '0;
        tick();
        tick();
        tick();
    endtask

    task test_corners;
        logic signed [8:0] ca [4];
        logic signed [8:0] cb [4];
        logic [16:0]       cr [4];
        logic              co [4];
        int waited;
        ca = '{-9'sd256, -9'sd256, 9'sd0,  9'sd255};
        cb = '{-9'sd256,  9'sd255, -9'sd1, 9'sd255};
        cr = '{17'h10000, 17'(-65280), 17'd0, 17'd65025};
        co = '{1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset();
        rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            op_a[t] = ca[t];
            op_b[t] = cb[t];
            req_valid = 4'(1 << t);
            #1;
            checks++; if (req_ready !== 4'(1 << t)) begin errors++; $display("FAIL corner_grant[%0d]: got %b want %b", t, req_ready, 4'(1 << t)); end
            tick();
            req_valid = '0;
            op_a[t] = 9'sd3;
            waited = 0;
            while (rsp_valid !== 1'b1 && waited < 10) begin
                tick();
                waited++;
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== cr[t] || rsp_ovf !== co[t] || rsp_id !== 2'(t)) begin
                errors++;
                $display("FAIL corner[%0d]: got rv=%b id=%0d res=%h ovf=%b want 1 %0d %h %b",
                         t, rsp_valid, rsp_id, rsp_result, rsp_ovf, t, cr[t], co[t]);
            end
            tick();
        end
    endtask

    task test_reset_mid;
        int seen;
        apply_reset();
        clear_ops();
        op_a[1] = 9'sd9;
        op_b[1] = 9'sd9;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        tick();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mul: got rv=%b busy=%b want 0 0", rsp_valid, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mul_ghost: got %0d active cycles want 0", seen); end
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        #2;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_setup: got rv=%b want 1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_result !== 17'd0) begin errors++; $display("FAIL rst_resp: got rv=%b res=%h want 0 0", rsp_valid, rsp_result); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
        req_valid = '0;
        tick();
        rsp_ready = 1'b1;
        tick();
        tick();
    endtask

    task test_random;
        int          last, cyc, ops, hs, e_id, pick, p;
        bit          inflight, exp_rv;
        logic [16:0] e_res;
        bit          e_ovf;
        logic [NREQ-1:0] exp_ready;
        int          grants [NREQ];
        int          resps  [NREQ];
        apply_reset();
        last = NREQ - 1;
        inflight = 0;
        ops = 0;
        hs = 0;
        e_id = 0;
        e_res = '0;
        e_ovf = 0;
        for (int k = 0; k < NREQ; k++) begin
            grants[k] = 0;
            resps[k] = 0;
        end
        cyc = 0;
        while (ops < 10000 && cyc < 60000) begin
            for (int k = 0; k < NREQ; k++) begin
                req_valid[k] = ($urandom_range(0, 3) != 0);
                op_a[k] = 9'($urandom);
                op_b[k] = 9'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = '0;
            pick = -1;
            if (!inflight) begin
                for (int j = 1; j <= NREQ; j++) begin
                    if (pick < 0 && req_valid[(last + j) % NREQ]) pick = (last + j) % NREQ;
                end
                if (pick >= 0) exp_ready[pick] = 1'b1;
            end
            exp_rv = inflight && (cyc >= hs + 2);
            checks++;
            if (req_ready !== exp_ready || busy !== inflight || rsp_valid !== exp_rv) begin
                errors++;
                $display("FAIL rand_ctrl@%0d: got rdy=%b busy=%b rv=%b want %b %b %b",
                         cyc, req_ready, busy, rsp_valid, exp_ready, inflight, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (rsp_id !== 2'(e_id) || rsp_result !== e_res || rsp_ovf !== e_ovf) begin
                    errors++;
                    $display("FAIL rand_rsp@%0d: got id=%0d res=%h ovf=%b want %0d %h %b",
                             cyc, rsp_id, rsp_result, rsp_ovf, e_id, e_res, e_ovf);
                end
                if (rsp_ready) begin
                    inflight = 0;
                    ops++;
                    resps[e_id]++;
                end
            end
            if (pick >= 0) begin
                inflight = 1;
                hs = cyc;
                e_id = pick;
                last = pick;
                grants[pick]++;
                p = int'(op_a[pick]) * int'(op_b[pick]);
                e_res = p[16:0];
                e_ovf = (p > 65535) || (p < -65536);
            end
            tick();
            cyc++;
        end
        checks++; if (ops < 10000) begin errors++; $display("FAIL rand_budget: got %0d ops want 10000", ops); end
        for (int k = 0; k < NREQ; k++) begin
            checks++;
            if (grants[k] == 0 || grants[k] - resps[k] > 1 || grants[k] < resps[k]) begin
                errors++;
                $display("FAIL rand_fair[%0d]: got grants=%0d resps=%0d want >0 and balanced", k, grants[k], resps[k]);
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        clear_ops();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_corners();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
